// File: rtl/crate_wr_pkg.sv
// Shared types, record layout constants and the record word packer for the
// crate write scheduler.
package crate_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GO,
        ST_PUSH,
        ST_WAIT_DONE
    } state_t;

    // One record is three 32-bit words: module, port, data.
    localparam int REC_BYTES = 12;
    localparam int REC_WORDS = 3;

    // Field positions inside the 10-bit crate address.
    localparam int MOD_LSB  = 0;
    localparam int MOD_W    = 5;
    localparam int PORT_LSB = 5;
    localparam int PORT_W   = 2;

    // Builds record word 'idx' from the latched address/data.
    // The module number on the bus is active-low, hence the inversion.
    function automatic logic [31:0] pack_word(input logic [1:0] idx,
                                              input logic [6:0] addr,
                                              input logic [7:0] data);
        logic [31:0] w;
        w = '0;
        case (idx)
            2'd0:    w[MOD_W-1:0]  = ~addr[MOD_LSB +: MOD_W];
            2'd1:    w[PORT_W-1:0] = addr[PORT_LSB +: PORT_W];
            default: w[7:0]        = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/crate_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1
// (wrapping) and returns the first requester as one-hot plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic [IDX_W-1:0] cand;

    // Rotating-priority search; the previous winner is checked last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/crate_write_scheduler.sv
// Shares one Avalon-MM burst write master between NUM_REQ crate capture
// channels. Each granted request becomes one 12-byte record written to a
// circular buffer in SDRAM.
module crate_write_scheduler
    import crate_wr_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h10004000,
    parameter int          RING_BYTES = 4092
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*10-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]  req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  control_fixed,
    output logic                  control_go,
    output logic [31:0]           control_write_base,
    output logic [31:0]           control_write_length,
    output logic [31:0]           user_buffer_input,
    output logic                  user_write_buffer,
    input  logic                  user_buffer_full,
    input  logic                  control_done,
    output logic                  busy,
    output logic [15:0]           records_written
);

    localparam int          IDX_W    = $clog2(NUM_REQ);
    localparam logic [31:0] RING_END = BASE_ADDR + 32'(RING_BYTES);

    state_t              state_reg;
    logic [IDX_W-1:0]    last_grant_reg;
    logic [NUM_REQ-1:0]  ack_reg;
    logic                go_reg;
    logic [1:0]          word_idx_reg;
    logic [6:0]          lat_addr_reg;
    logic [7:0]          lat_data_reg;
    logic [31:0]         hold_reg;
    logic [31:0]         ptr_reg;
    logic [15:0]         rec_cnt_reg;
    logic                done_seen_reg;

    logic [6:0]          chan_addr [NUM_REQ];
    logic [7:0]          chan_data [NUM_REQ];
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                any_req;
    logic [31:0]         word_cur;
    logic [31:0]         ptr_inc;

    // Address bits [9:7] carry the valid-module field, which the record
    // does not store.
    logic [NUM_REQ*10-1:0] unused_req_addr;
    assign unused_req_addr = req_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign chan_addr[gi] = req_addr[10*gi +: 7];
            assign chan_data[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_req    (any_req)
    );

    assign word_cur = pack_word(word_idx_reg, lat_addr_reg, lat_data_reg);
    assign ptr_inc  = ptr_reg + 32'(REC_BYTES);

    // The FIFO qualifier follows 'full' in the same cycle so no word is
    // offered while the FIFO cannot take it; between writes the data bus
    // keeps showing the last word written.
    assign user_write_buffer    = (state_reg == ST_PUSH) && !user_buffer_full;
    assign user_buffer_input    = user_write_buffer ? word_cur : hold_reg;
    assign ack                  = ack_reg;
    assign control_go           = go_reg;
    assign control_fixed        = 1'b0;
    assign control_write_length = 32'(REC_BYTES);
    assign control_write_base   = ptr_reg;
    assign busy                 = (state_reg != ST_IDLE);
    assign records_written      = rec_cnt_reg;

    // Record sequencer. Latch/ack/last_grant are registered on the edge into
    // LOAD so that ack is visible during LOAD, one cycle after the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            ack_reg        <= '0;
            go_reg         <= 1'b0;
            word_idx_reg   <= 2'd0;
            lat_addr_reg   <= '0;
            lat_data_reg   <= '0;
            hold_reg       <= '0;
            ptr_reg        <= BASE_ADDR;
            rec_cnt_reg    <= '0;
            done_seen_reg  <= 1'b0;
        end else begin
            ack_reg <= '0;
            go_reg  <= 1'b0;

            // A done that shows up before WAIT_DONE is remembered.
            if (control_done && (state_reg == ST_LOAD || state_reg == ST_GO ||
                                 state_reg == ST_PUSH)) begin
                done_seen_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        lat_addr_reg   <= chan_addr[grant_idx];
                        lat_data_reg   <= chan_data[grant_idx];
                        ack_reg        <= grant;
                        last_grant_reg <= grant_idx;
                        state_reg      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    go_reg    <= 1'b1;
                    state_reg <= ST_GO;
                end
                ST_GO: begin
                    word_idx_reg <= 2'd0;
                    state_reg    <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (!user_buffer_full) begin
                        hold_reg <= word_cur;
                        if (word_idx_reg == 2'(REC_WORDS - 1)) begin
                            state_reg <= ST_WAIT_DONE;
                        end else begin
                            word_idx_reg <= word_idx_reg + 2'd1;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (control_done || done_seen_reg) begin
                        ptr_reg       <= (ptr_inc >= RING_END) ? BASE_ADDR : ptr_inc;
                        rec_cnt_reg   <= rec_cnt_reg + 16'd1;
                        done_seen_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crate_write_scheduler.sv
// Self-checking bench for crate_write_scheduler: directed scenarios plus a
// randomized ring run, checked against a transaction-level model.
module tb_crate_write_scheduler;

    localparam int          NR   = 4;
    localparam logic [31:0] BASE = 32'h10004000;
    localparam int          RING = 4092;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*10-1:0]  req_addr;
    logic [NR*8-1:0]   req_data;
    logic [NR-1:0]     ack;
    logic              control_fixed;
    logic              control_go;
    logic [31:0]       control_write_base;
    logic [31:0]       control_write_length;
    logic [31:0]       user_buffer_input;
    logic              user_write_buffer;
    logic              user_buffer_full;
    logic              control_done;
    logic              busy;
    logic [15:0]       records_written;

    int          a_q [NR];
    int          d_q [NR];
    int          total = 0;
    int          bad   = 0;
    int          m_last;
    longint      m_ptr;
    int          m_count;
    logic [31:0] last_wr;
    int          t_ack;
    int          t_wr [3];
    logic [31:0] wr_val [3];
    int          ch;
    int          rr_exp [5] = '{0, 1, 2, 3, 0};

    crate_write_scheduler #(
        .NUM_REQ    (NR),
        .BASE_ADDR  (BASE),
        .RING_BYTES (RING)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req                  (req),
        .req_addr             (req_addr),
        .req_data             (req_data),
        .ack                  (ack),
        .control_fixed        (control_fixed),
        .control_go           (control_go),
        .control_write_base   (control_write_base),
        .control_write_length (control_write_length),
        .user_buffer_input    (user_buffer_input),
        .user_write_buffer    (user_write_buffer),
        .user_buffer_full     (user_buffer_full),
        .control_done         (control_done),
        .busy                 (busy),
        .records_written      (records_written)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[10*i +: 10] = 10'(a_q[i]);
            req_data[8*i +: 8]   = 8'(d_q[i]);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next requester after 'last' going upward, wrapping; -1 if none.
    function automatic int rr_pick(input int last, input logic [NR-1:0] r);
        int c;
        c = last;
        repeat (NR) begin
            c = (c + 1) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Record word k for crate address a / data d, from the field definitions.
    function automatic int exp_word(input int a, input int d, input int k);
        if (k == 0) return 31 - (a % 32);
        if (k == 1) return (a / 32) % 4;
        return d;
    endfunction

    task automatic model_reset();
        m_last  = NR - 1;
        m_ptr   = longint'(BASE);
        m_count = 0;
        last_wr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        user_buffer_full = 1'b0;
        control_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic raise_random();
        int c;
        c = $urandom_range(NR - 1, 0);
        req[c] = 1'b1;
        a_q[c] = $urandom_range(1023, 0);
        d_q[c] = $urandom_range(255, 0);
    endtask

    // One complete record, starting from a cycle in which the DUT is idle.
    // mode: 0 random new requests after ack, 1 keep all requesting, 2 none.
    task automatic run_record(input int full_pct, input int done_dly, input bit early,
                              input int mode, input bit stall, input int abort_after,
                              output int win);
        int          w, t, k, n, stall_cnt;
        logic [31:0] exp_w [3];
        logic [31:0] base0;
        bit          got;
        win = -1;
        w = rr_pick(m_last, req);
        if (w < 0) begin
            total++;
            bad++;
            $display("FAIL no_request got=0 exp=nonzero");
            return;
        end
        base0 = 32'(m_ptr);
        for (int i = 0; i < 3; i++) exp_w[i] = 32'(exp_word(a_q[w], d_q[w], i));

        got = 1'b0;
        t = 0;
        for (n = 0; n < 6 && !got; n++) begin
            tick();
            user_buffer_full = 1'b0;
            control_done = 1'b0;
            #1;
            t++;
            got = (ack != '0);
        end
        t_ack = t;
        check_val("ack_onehot", 32'(ack), 32'(1) << w);
        if (!got) return;
        for (int i = 0; i < NR; i++) if (ack[i]) win = i;
        check_val("busy_load", 32'(busy), 32'd1);

        for (int c = 0; c < NR; c++) begin
            if (c == w || !req[c]) begin
                if (mode == 1 || (mode == 0 && $urandom_range(1, 0) == 1)) begin
                    req[c] = 1'b1;
                    a_q[c] = $urandom_range(1023, 0);
                    d_q[c] = $urandom_range(255, 0);
                end else if (c == w) begin
                    req[c] = 1'b0;
                end
            end
        end

        tick();
        control_done = 1'b0;
        #1;
        t++;
        check_val("go_pulse", 32'(control_go), 32'd1);
        check_val("go_base", control_write_base, base0);
        check_val("go_len", control_write_length, 32'd12);
        check_val("go_fixed", 32'(control_fixed), 32'd0);
        check_val("ack_cleared", 32'(ack), 32'd0);

        k = 0;
        stall_cnt = 0;
        for (n = 0; n < 60 && k < 3; n++) begin
            tick();
            control_done = early && (n == 0);
            if (stall && k == 1 && stall_cnt < 5) begin
                user_buffer_full = 1'b1;
                stall_cnt++;
            end else begin
                user_buffer_full = ($urandom_range(99, 0) < full_pct);
            end
            #1;
            t++;
            check_val("wr_qual", 32'(user_write_buffer), 32'(!user_buffer_full));
            if (user_write_buffer) begin
                check_val("word", user_buffer_input, exp_w[k]);
                wr_val[k] = user_buffer_input;
                t_wr[k] = t;
                last_wr = user_buffer_input;
                k++;
            end else begin
                check_val("hold", user_buffer_input, last_wr);
            end
            if (abort_after > 0 && k == abort_after) return;
        end
        control_done = 1'b0;
        user_buffer_full = 1'b0;
        if (k < 3) begin
            check_val("push_timeout", 32'(k), 32'd3);
            return;
        end

        for (n = 0; n < done_dly; n++) begin
            tick();
            control_done = 1'b0;
            user_buffer_full = 1'($urandom_range(1, 0));
            #1;
            t++;
            check_val("wait_busy", 32'(busy), 32'd1);
            check_val("wait_nowr", 32'(user_write_buffer), 32'd0);
            check_val("wait_base", control_write_base, base0);
        end
        tick();
        control_done = !early;
        user_buffer_full = 1'b0;
        #1;
        t++;
        check_val("done_cycle_busy", 32'(busy), 32'd1);
        check_val("done_cycle_base", control_write_base, base0);
        tick();
        control_done = 1'b0;
        #1;
        t++;
        m_ptr = (m_ptr + 12 >= longint'(BASE) + RING) ? longint'(BASE) : m_ptr + 12;
        m_count++;
        m_last = w;
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("next_base", control_write_base, 32'(m_ptr));
        check_val("rec_count", 32'(records_written), 32'(m_count % 65536));
        $display("rec %0d ch=%0d base=%h", m_count, win, base0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            a_q[i] = 0;
            d_q[i] = 0;
        end
        reset = 1'b1;
        req = '0;
        user_buffer_full = 1'b0;
        control_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_go", 32'(control_go), 32'd0);
        check_val("rst_fixed", 32'(control_fixed), 32'd0);
        check_val("rst_wb", 32'(user_write_buffer), 32'd0);
        check_val("rst_data", user_buffer_input, 32'd0);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_count", 32'(records_written), 32'd0);
        check_val("rst_base", control_write_base, BASE);
        check_val("rst_len", control_write_length, 32'd12);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single request on channel 0, FIFO never full.
        a_q[0] = 'h03A;
        d_q[0] = 'hC5;
        req = 4'b0001;
        run_record(0, 2, 1'b0, 2, 1'b0, 0, ch);
        check_val("single_ch", 32'(ch), 32'd0);
        check_val("single_ack_lat", 32'(t_ack), 32'd1);
        check_val("single_w0_lat", 32'(t_wr[0]), 32'd3);
        check_val("single_w1_lat", 32'(t_wr[1]), 32'd4);
        check_val("single_w2_lat", 32'(t_wr[2]), 32'd5);
        check_val("single_w0", wr_val[0], 32'h5);
        check_val("single_w1", wr_val[1], 32'h1);
        check_val("single_w2", wr_val[2], 32'hC5);
        check_val("single_base", control_write_base, 32'h1000400C);
        check_val("single_count", 32'(records_written), 32'd1);

        // Round-robin fairness with all channels requesting.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_q[i] = $urandom_range(1023, 0);
            d_q[i] = $urandom_range(255, 0);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_record(0, 3, 1'b0, 1, 1'b0, 0, ch);
            check_val("rr_order", 32'(ch), 32'(rr_exp[i]));
        end

        // Back-pressure: FIFO full for 5 cycles after word0.
        req = 4'b0100;
        a_q[2] = 'h1FF;
        d_q[2] = 'h3C;
        run_record(0, 1, 1'b0, 2, 1'b1, 0, ch);
        check_val("bp_ch", 32'(ch), 32'd2);
        check_val("bp_w1_gap", 32'(t_wr[1] - t_wr[0]), 32'd6);
        check_val("bp_w2_gap", 32'(t_wr[2] - t_wr[1]), 32'd1);
        check_val("bp_w1", wr_val[1], 32'h3);

        // Early done pulsed during PUSH.
        for (int i = 0; i < 3; i++) begin
            if (req == '0) raise_random();
            run_record(25, 0, 1'b1, 0, 1'b0, 0, ch);
        end

        // Ring wrap with randomized requests, back-pressure and done timing.
        do_reset();
        for (int r = 1; r <= 342; r++) begin
            bit e;
            if (req == '0) raise_random();
            if (r == 341) check_val("ring_341_base", control_write_base, 32'h10004FF0);
            if (r == 342) check_val("ring_342_base", control_write_base, 32'h10004000);
            e = ($urandom_range(3, 0) == 0);
            run_record(20, e ? 0 : int'($urandom_range(2, 0)), e, 0, 1'b0, 0, ch);
        end

        // Reset in PUSH after word1.
        if (req == '0) raise_random();
        run_record(0, 0, 1'b0, 2, 1'b0, 2, ch);
        reset = 1'b1;
        #1;
        check_val("mid_rst_go", 32'(control_go), 32'd0);
        check_val("mid_rst_wb", 32'(user_write_buffer), 32'd0);
        check_val("mid_rst_data", user_buffer_input, 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_ack", 32'(ack), 32'd0);
        check_val("mid_rst_count", 32'(records_written), 32'd0);
        check_val("mid_rst_base", control_write_base, BASE);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) begin
            a_q[i] = $urandom_range(1023, 0);
            d_q[i] = $urandom_range(255, 0);
        end
        req = 4'b1111;
        run_record(0, 1, 1'b0, 2, 1'b0, 0, ch);
        check_val("post_rst_ch", 32'(ch), 32'd0);
        check_val("post_rst_base", control_write_base, 32'h1000400C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crate_write_scheduler.md
# crate_write_scheduler

Shares one Avalon-MM burst write master between NUM_REQ crate-bus capture channels. Arbitrates round-robin, latches the winner's address/data, and sequences the master through one 12-byte record (module, port, data). Writes successive records into a circular buffer in SDRAM. It sits between the crate-bus capture front ends and the write master's control/user ports, and replaces per-channel free-running write sequencing.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting capture channels (2..8)
- BASE_ADDR, 32'h10004000, byte address of ring start
- RING_BYTES, 4092, ring size in bytes; must be a multiple of 12

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-channel request; held high until matching ack
- req_addr  in  NUM_REQ*10  packed crate address A[9:0] per channel (channel i at [10i+9:10i])
- req_data  in  NUM_REQ*8  packed crate data D[7:0] per channel
- ack  out  NUM_REQ  one-cycle pulse: channel's record latched
- control_fixed  out  1  constant 0 (incrementing addresses)
- control_go  out  1  one-cycle start pulse to write master
- control_write_base  out  32  byte address of current record
- control_write_length  out  32  constant 12
- user_buffer_input  out  32  write-FIFO data word
- user_write_buffer  out  1  write-FIFO qualifier
- user_buffer_full  in  1  write-FIFO full
- control_done  in  1  write master finished transfer
- busy  out  1  high in any state except IDLE
- records_written  out  16  count of completed records, wraps at 2^16

## Operation
- States: IDLE, LOAD, GO, PUSH, WAIT_DONE.
- IDLE: if any req is high, go to LOAD. The rr_arbiter picks the winner, starting the search at last_grant+1 modulo NUM_REQ.
- LOAD: latch the winner's req_addr/req_data, pulse ack[winner], update last_grant, then go to GO.
- GO: control_go=1 for exactly this cycle. control_write_base holds the ring pointer. Next state is PUSH with word index 0.
- PUSH: when user_buffer_full=0, assert user_write_buffer and drive the word for the current index, then advance the index.
  - word0 = {27'b0, ~addr[4:0]} (module)
  - word1 = {30'b0, addr[6:5]} (port)
  - word2 = {24'b0, data}
  - When full=1: user_write_buffer=0, the index holds, and user_buffer_input holds its last value.
  - After word2 is written, go to WAIT_DONE.
- WAIT_DONE: on control_done (level or pulse), or a done_seen flag set earlier, do three things in the same cycle:
  - advance the pointer: ptr+12; if ptr+12 ≥ BASE_ADDR+RING_BYTES then BASE_ADDR
  - increment records_written and clear done_seen
  - go to IDLE
- control_done during LOAD, GO or PUSH sets done_seen. It is never lost.
- addr[9:7] (valid-module field) is ignored.
- Record is committed at ack: dropping req after ack has no effect. Dropping req before ack withdraws the request silently.
- All arithmetic on the pointer is 32-bit unsigned. The wrap comparison is done before the write-back.

## Timing
- Reset values:
  - control_go=0, control_fixed=0, user_write_buffer=0, user_buffer_input=0, ack=0, busy=0, records_written=0
  - control_write_base=BASE_ADDR, control_write_length=12
  - last_grant=NUM_REQ-1 (so channel 0 wins first), done_seen=0, state IDLE
- Latency with req high in IDLE at cycle N and FIFO never full:
  - ack at N+1, control_go at N+2
  - words at N+3, N+4, N+5
  - WAIT_DONE from N+6
  - If control_done arrives at cycle M, IDLE is reached at M+1 and the next LOAD at M+2.
- control_write_base is stable from GO through WAIT_DONE exit. It changes only on the cycle leaving WAIT_DONE.
- Only one record is in flight; no new arbitration until IDLE.
- Reset mid-record: all state returns to reset values immediately, the partial record is abandoned, and no ack is reissued. Flushing the master is the integrator's responsibility.

## Structure
- Package crate_wr_pkg holds:
  - state enum
  - REC_BYTES=12, REC_WORDS=3
  - word-packing field offsets (MOD_LSB=0/5 bits, PORT_LSB=5/2 bits)
- Sub-module rr_arbiter(NUM_REQ): combinational one-hot grant from req and last_grant. Registered last_grant lives in the parent.

## Test plan
- Single request: channel 0, A=10'h03A, D=8'hC5, FIFO never full -> ack[0] at N+1, go at N+2; words 32'h5, 32'h1, 32'hC5 at N+3..N+5; base 32'h10004000; after done, base 32'h1000400C and records_written=1.
- Round-robin fairness: all 4 req held high, done returned 3 cycles after WAIT_DONE entry -> ack order 0,1,2,3,0.
- Back-pressure: user_buffer_full high for 5 cycles after word0 -> user_write_buffer low during stall; word1 is written on the first cycle full=0 with the value unchanged; exactly 3 writes total.
- Ring wrap: 341 consecutive records -> record 341 at base 32'h10004FF0; record 342 at 32'h10004000.
- Early done: control_done pulsed during PUSH -> WAIT_DONE exits on its first cycle, with no hang.
- Reset in PUSH after word1 -> all outputs at reset values next cycle; next request is granted to channel 0 at base 32'h10004000.
